// File: rtl/fp_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_rnd_pipe
// Purpose  : Two-stage single-precision rounding and packing stage. Takes
//            an unrounded record (sign, biased exponent, 24-bit significand,
//            guard/round/sticky, rounding mode, special-case flags) and emits
//            the packed binary32 result with {NV,DZ,OF,UF,NX} flags.
//            S1 applies the rounding increment; S2 normalises and packs.
// Ports    : clock, reset (sync, active-high)
//            in_valid/in_ready + in_sig, in_expo, in_mant, in_grs, in_rm,
//            in_snan, in_qnan, in_dbz, in_inf, in_zero  : input record
//            kill                                       : flush in-flight
//            out_valid/out_ready, out_result, out_flags : packed result
// Options  : FP_RND_SKID_EN - registered in_ready/out_valid through a
//            2-entry output skid queue (no out_ready->in_ready comb path).
// Revision : 1.0 - initial release
// ============================================================================
module fp_rnd_pipe #(
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sig,
  input  logic [9:0]  in_expo,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  input  logic [2:0]  in_rm,
  input  logic        in_snan,
  input  logic        in_qnan,
  input  logic        in_dbz,
  input  logic        in_inf,
  input  logic        in_zero,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);

  if (LATENCY != 2) begin : g_latency_check
    $error("fp_rnd_pipe: only LATENCY=2 is supported");
  end

  localparam logic [2:0] c_RM_RTZ = 3'd1;
  localparam logic [2:0] c_RM_RDN = 3'd2;
  localparam logic [2:0] c_RM_RUP = 3'd3;
  localparam logic [2:0] c_RM_RMM = 3'd4;

  logic w_xfer;
  logic w_s1_load;

  // ---------------- S1: rounding increment ----------------
  logic        w_g, w_rs, w_inexact, w_inc;
  logic [24:0] w_mant_r;

  assign w_g       = in_grs[2];
  assign w_rs      = in_grs[1] | in_grs[0];
  assign w_inexact = |in_grs;

  always_comb begin
    w_inc = 1'b0;
    case (in_rm)
      c_RM_RTZ: w_inc = 1'b0;
      c_RM_RDN: w_inc = in_sig & w_inexact;
      c_RM_RUP: w_inc = ~in_sig & w_inexact;
      c_RM_RMM: w_inc = w_g;
      default:  w_inc = w_g & (in_mant[0] | w_rs);  // RNE, also rm 5..7
    endcase
  end

  assign w_mant_r = in_mant + {24'd0, w_inc};

  logic        r_s1_valid, r_s1_sig, r_s1_inexact;
  logic [9:0]  r_s1_expo;
  logic [24:0] r_s1_mant;
  logic [2:0]  r_s1_rm;
  logic        r_s1_snan, r_s1_qnan, r_s1_dbz, r_s1_inf, r_s1_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_sig     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_expo    <= '0;
      r_s1_mant    <= '0;
      r_s1_rm      <= '0;
      r_s1_snan    <= 1'b0;
      r_s1_qnan    <= 1'b0;
      r_s1_dbz     <= 1'b0;
      r_s1_inf     <= 1'b0;
      r_s1_zero    <= 1'b0;
    end else begin
      if (kill)
        r_s1_valid <= 1'b0;
      else if (w_s1_load)
        r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_sig     <= in_sig;
        r_s1_inexact <= w_inexact;
        r_s1_expo    <= in_expo;
        r_s1_mant    <= w_mant_r;
        r_s1_rm      <= in_rm;
        r_s1_snan    <= in_snan;
        r_s1_qnan    <= in_qnan;
        r_s1_dbz     <= in_dbz;
        r_s1_inf     <= in_inf;
        r_s1_zero    <= in_zero;
      end
    end
  end

  // ---------------- S2 combinational: normalise and pack ----------------
  logic [23:0] w_mant_n;
  logic [10:0] w_expo_n;
  logic [7:0]  w_exp_field;
  logic        w_ovf, w_tiny, w_to_inf;
  logic [31:0] w_res;
  logic [4:0]  w_flg;

  assign w_mant_n = r_s1_mant[24] ? r_s1_mant[24:1] : r_s1_mant[23:0];
  assign w_expo_n = {1'b0, r_s1_expo} + {10'd0, r_s1_mant[24]};
  assign w_ovf    = (w_expo_n >= 11'd255);
  assign w_tiny   = (r_s1_expo == 10'd0);
  // Subnormal input: a round-up into the hidden bit promotes the field to 1.
  assign w_exp_field = w_tiny ? {7'd0, w_mant_n[23]} : w_expo_n[7:0];

  // Overflow saturates to infinity only when rounding away from zero.
  always_comb begin
    w_to_inf = 1'b1;
    case (r_s1_rm)
      c_RM_RTZ: w_to_inf = 1'b0;
      c_RM_RDN: w_to_inf = r_s1_sig;
      c_RM_RUP: w_to_inf = ~r_s1_sig;
      default:  w_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    w_res = 32'd0;
    w_flg = 5'd0;
    if (r_s1_snan | r_s1_qnan) begin
      w_res = 32'h7FC0_0000;
      w_flg = {r_s1_snan, 4'b0000};
    end else if (r_s1_inf) begin
      w_res = {r_s1_sig, 8'hFF, 23'd0};
      w_flg = {1'b0, r_s1_dbz, 3'b000};
    end else if (r_s1_zero) begin
      w_res = {r_s1_sig, 31'd0};
    end else if (w_ovf) begin
      w_res = w_to_inf ? {r_s1_sig, 8'hFF, 23'd0} : {r_s1_sig, 8'hFE, 23'h7F_FFFF};
      w_flg = 5'b00101;
    end else begin
      w_res = {r_s1_sig, w_exp_field, w_mant_n[22:0]};
      w_flg = {3'b000, w_tiny & r_s1_inexact, r_s1_inexact};
    end
  end

`ifdef FP_RND_SKID_EN
  // ---------------- Output skid queue (head drives the outputs) ----------------
  logic        r_q0_valid, r_q1_valid, r_in_ready;
  logic [31:0] r_q0_result, r_q1_result;
  logic [4:0]  r_q0_flags, r_q1_flags;
  logic        w_pop, w_push, w_n_s1_valid, w_n_q0_valid, w_n_q1_valid;

  assign w_pop     = r_q0_valid & out_ready;
  assign w_push    = r_s1_valid & ~r_q1_valid;
  assign w_s1_load = ~r_s1_valid | w_push;
  assign w_xfer    = in_valid & r_in_ready;

  assign w_n_s1_valid = ~kill & (w_s1_load ? w_xfer : r_s1_valid);
  assign w_n_q0_valid = ~kill & (w_push | (w_pop ? r_q1_valid : r_q0_valid));
  assign w_n_q1_valid = ~kill & ((w_push & ~w_pop & r_q0_valid) | (~w_pop & r_q1_valid));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q0_valid  <= 1'b0;
      r_q1_valid  <= 1'b0;
      r_q0_result <= '0;
      r_q1_result <= '0;
      r_q0_flags  <= '0;
      r_q1_flags  <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      // A push only happens with q1 empty, so pop+push simply refills the head.
      if (w_pop && w_push) begin
        r_q0_result <= w_res;
        r_q0_flags  <= w_flg;
      end else if (w_pop) begin
        r_q0_result <= r_q1_result;
        r_q0_flags  <= r_q1_flags;
      end else if (w_push) begin
        if (!r_q0_valid) begin
          r_q0_result <= w_res;
          r_q0_flags  <= w_flg;
        end else begin
          r_q1_result <= w_res;
          r_q1_flags  <= w_flg;
        end
      end
      r_q0_valid <= w_n_q0_valid;
      r_q1_valid <= w_n_q1_valid;
      // Accept next cycle only if S1 is guaranteed free even with no pop.
      r_in_ready <= ~w_n_s1_valid | ~w_n_q1_valid;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_q0_valid;
  assign out_result = r_q0_result;
  assign out_flags  = r_q0_flags;
`else
  // ---------------- S2 register ----------------
  logic        r_s2_valid;
  logic [31:0] r_s2_result;
  logic [4:0]  r_s2_flags;
  logic        w_s2_load;

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_xfer    = in_valid & w_s1_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else begin
      if (kill)
        r_s2_valid <= 1'b0;
      else if (w_s2_load)
        r_s2_valid <= r_s1_valid;
      if (w_s2_load && r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_flags  <= w_flg;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flags  = r_s2_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_rnd_pipe
// Purpose  : Scoreboard bench for fp_rnd_pipe. The driver pushes the
//            expected {result,flags} of every accepted record; a monitor pops
//            and compares on each output handshake and checks that a stalled
//            output holds steady.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_rnd_pipe;

  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic        snan, qnan, dbz, inf, zero;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, in_sig, in_snan, in_qnan, in_dbz, in_inf, in_zero;
  logic [9:0]  in_expo;
  logic [24:0] in_mant;
  logic [2:0]  in_grs, in_rm;
  logic        kill, out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  fp_rnd_pipe #(.LATENCY(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_expo(in_expo), .in_mant(in_mant), .in_grs(in_grs),
    .in_rm(in_rm), .in_snan(in_snan), .in_qnan(in_qnan), .in_dbz(in_dbz),
    .in_inf(in_inf), .in_zero(in_zero), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clock = ~clock;

  // Reference: value-level IEEE rounding of sig * M * 2^(E) with a 3-bit tail.
  function automatic logic [36:0] model(input rec_t r);
    int unsigned m, e, field;
    bit nz, up, big;
    logic [31:0] res;
    logic [4:0]  flg;
    if (r.snan || r.qnan) return {32'h7FC00000, r.snan, 4'b0000};
    if (r.inf)  return {r.sig, 8'hFF, 23'd0, 1'b0, r.dbz, 3'b000};
    if (r.zero) return {r.sig, 31'd0, 5'd0};
    m  = r.mant;
    e  = r.expo;
    nz = (r.grs != 0);
    case (r.rm)
      3'd1:    up = 0;
      3'd2:    up = r.sig && nz;
      3'd3:    up = !r.sig && nz;
      3'd4:    up = (r.grs >= 3'd4);                        // tail >= half
      default: up = (r.grs > 3'd4) || (r.grs == 3'd4 && (m % 2) == 1);
    endcase
    m = m + (up ? 1 : 0);
    if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end
    if (e >= 255) begin
      big = (r.rm == 3'd1) ? 0 : (r.rm == 3'd2) ? r.sig : (r.rm == 3'd3) ? !r.sig : 1;
      res = big ? {r.sig, 8'hFF, 23'd0} : {r.sig, 8'hFE, 23'h7FFFFF};
      flg = 5'b00101;
    end else begin
      field = (r.expo == 0) ? ((m >> 23) & 1) : e;
      res = {r.sig, 8'(field), 23'(m % (1 << 23))};
      flg = {3'b000, (r.expo == 0) && nz, nz};
    end
    return {res, flg};
  endfunction

  function automatic rec_t mk(input bit s, input int unsigned ex, input int unsigned mn,
                              input bit [2:0] g, input bit [2:0] rm);
    rec_t r;
    r = '0;
    r.sig = s; r.expo = 10'(ex); r.mant = 25'(mn); r.grs = g; r.rm = rm;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    int unsigned sel;
    r = '0;
    r.sig = 1'($urandom);
    sel = $urandom_range(0, 7);
    case (sel)
      0:       r.expo = 10'd0;
      1:       r.expo = 10'($urandom_range(253, 255));
      2:       r.expo = 10'($urandom_range(256, 1023));
      default: r.expo = 10'($urandom_range(1, 252));
    endcase
    r.mant = {1'b0, (r.expo != 0), 23'($urandom)};
    if ($urandom_range(0, 3) == 0) r.mant[22:0] = 23'h7FFFFF;
    r.grs  = 3'($urandom);
    r.rm   = 3'($urandom);
    r.snan = ($urandom_range(0, 15) == 0);
    r.qnan = ($urandom_range(0, 15) == 0);
    r.inf  = ($urandom_range(0, 15) == 0);
    r.zero = ($urandom_range(0, 15) == 0);
    r.dbz  = 1'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One clock of stimulus: drive at negedge, decide acceptance before posedge.
  task automatic do_cycle(input bit v, input rec_t r, input bit ordy, input bit k,
                          input bit rs, input bit use_c, input logic [36:0] cexp,
                          output bit acc);
    @(negedge clock);
    in_valid = v;  in_sig = r.sig; in_expo = r.expo; in_mant = r.mant;
    in_grs = r.grs; in_rm = r.rm; in_snan = r.snan; in_qnan = r.qnan;
    in_dbz = r.dbz; in_inf = r.inf; in_zero = r.zero;
    out_ready = ordy; kill = k; reset = rs;
    #1;
    acc = v && in_ready && !k && !rs;
    if (acc) exp_q.push_back(use_c ? cexp : model(r));
  endtask

  task automatic idle(input bit ordy);
    bit a;
    do_cycle(0, '0, ordy, 0, 0, 0, '0, a);
  endtask

  task automatic send(input rec_t r, input bit use_c, input logic [36:0] cexp);
    bit a;
    int n;
    n = 0;
    a = 0;
    while (!a && n < 50) begin
      do_cycle(1, r, 1, 0, 0, use_c, cexp, a);
      n++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
    repeat (3) idle(1);
  endtask

  // Monitor: compare on every output handshake; a stalled output must hold.
  initial begin
    logic [36:0] prev, e;
    bit hold;
    hold = 0;
    prev = '0;
    forever begin
      @(negedge clock);
      #2;
      if (reset || kill) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        total++;
        if (!out_valid || {out_result, out_flags} !== prev) begin
          bad++;
          $display("FAIL hold_stable actual=%b/%h/%b required=1/%h/%b",
                   out_valid, out_result, out_flags, prev[36:5], prev[4:0]);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output actual=%h/%b required=none", out_result, out_flags);
        end else begin
          e = exp_q.pop_front();
          if ({out_result, out_flags} !== e) begin
            bad++;
            $display("FAIL result actual=%h/%b required=%h/%b",
                     out_result, out_flags, e[36:5], e[4:0]);
          end
        end
      end
      hold = out_valid && !out_ready;
      prev = {out_result, out_flags};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r, recs[4];
    bit a, saw_drop;
    int sent;
    reset = 1; kill = 0; in_valid = 0; out_ready = 0;
    in_sig = 0; in_expo = 0; in_mant = 0; in_grs = 0; in_rm = 0;
    in_snan = 0; in_qnan = 0; in_dbz = 0; in_inf = 0; in_zero = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    idle(1);
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_out_result", 64'(out_result), 0);
    chk("reset_out_flags", 64'(out_flags), 0);
    chk("reset_in_ready", 64'(in_ready), 1);

    // Directed: latency and known vectors.
    send(mk(0, 127, 24'h800000, 3'b000, 0), 1, {32'h3F800000, 5'b00000});
    idle(1);
    chk("latency_edge1", 64'(out_valid), 0);
    idle(1);
    chk("latency_edge2", 64'(out_valid), 1);
    send(mk(0, 158, 24'hFFFFFF, 3'b111, 0), 0, '0);
    send(mk(0, 158, 24'hFFFFFF, 3'b111, 1), 0, '0);
    send(mk(0, 254, 24'hFFFFFF, 3'b100, 0), 1, {32'h7F800000, 5'b00101});
    send(mk(1, 255, 24'h800000, 3'b000, 1), 1, {32'hFF7FFFFF, 5'b00101});
    r = mk(0, 10, 24'h800000, 0, 0); r.snan = 1;
    send(r, 1, {32'h7FC00000, 5'b10000});
    r = mk(1, 10, 24'h800000, 0, 0); r.inf = 1; r.dbz = 1;
    send(r, 1, {32'hFF800000, 5'b01000});
    send(mk(0, 0, 24'h7FFFFF, 3'b110, 0), 1, {32'h00800000, 5'b00011});
    r = mk(1, 200, 24'hABCDEF, 3'b111, 2); r.zero = 1;
    send(r, 1, {32'h80000000, 5'b00000});
    drain();

    // Backpressure: 4 records, out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 4; i++) recs[i] = mk(i[0], 100 + i, 24'h800000 + i, 3'(i * 3), 3'(i));
    sent = 0;
    saw_drop = 0;
    for (int c = 0; c < 30; c++) begin
      do_cycle(sent < 4, recs[sent % 4], !(c >= 2 && c < 7), 0, 0, 0, '0, a);
      if (a) sent++;
      if (c >= 2 && c < 7 && !in_ready) saw_drop = 1;
    end
    chk("stall_in_ready_drop", 64'(saw_drop), 1);
    chk("stall_all_accepted", 64'(sent), 4);
    drain();

    // kill with two records in flight (plus one offered in the kill cycle).
    do_cycle(1, rnd_rec(), 0, 0, 0, 0, '0, a);
    do_cycle(1, rnd_rec(), 0, 0, 0, 0, '0, a);
    do_cycle(1, rnd_rec(), 0, 1, 0, 0, '0, a);
    exp_q.delete();
    idle(1);
    chk("kill_out_valid", 64'(out_valid), 0);
    repeat (5) idle(1);

    // reset with two records in flight.
    do_cycle(1, rnd_rec(), 0, 0, 0, 0, '0, a);
    do_cycle(1, rnd_rec(), 0, 0, 0, 0, '0, a);
    do_cycle(1, rnd_rec(), 0, 0, 1, 0, '0, a);
    exp_q.delete();
    idle(1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_result", 64'(out_result), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    repeat (5) idle(1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++)
      do_cycle($urandom_range(0, 3) != 0, rnd_rec(), $urandom_range(0, 9) < 7, 0, 0, 0, '0, a);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
